proj_extender_ctrl: RTL and testbench

PROJ_EXTENDER_CTRL -- requirements
Module: proj_extender_ctrl

---
 rtl/proj_pkg.sv | 16 +
 rtl/proj_extender_ctrl.sv | 113 +++++++++++
 tb/tb_proj_extender_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - shared widths and job record for the sorter-to-extender path
package proj_pkg;

    localparam int FM_EXTENDER_FRAG_LEN_BITS     = 32;
    localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
    localparam int INDICE_LEN                    = 8;
    localparam int EXTENDER_FRAG_PARTS_COUNT     = 8;
    localparam int EXTENDER_JOB_CNT_BITS         = $clog2(SORTER_EXTENDER_INDICES_COUNT) + 1;

    typedef struct packed {
        logic [FM_EXTENDER_FRAG_LEN_BITS-1:0]                            frag;
        logic [SORTER_EXTENDER_INDICES_COUNT-1:0][INDICE_LEN-1:0]       indices;
        logic [EXTENDER_JOB_CNT_BITS-1:0]                                cnt;
    } extender_job_t;

endpackage

// File: rtl/proj_extender_ctrl.sv
// rtl/proj_extender_ctrl.sv - feeds jobs to the free-running extender, one job per counter round
module proj_extender_ctrl
    import proj_pkg::*;
#(
    parameter int FRAG_LEN_BITS    = FM_EXTENDER_FRAG_LEN_BITS,
    parameter int FRAG_PARTS_COUNT = EXTENDER_FRAG_PARTS_COUNT,
    parameter int INDICES_COUNT    = SORTER_EXTENDER_INDICES_COUNT,
    parameter int INDICE_LEN       = proj_pkg::INDICE_LEN
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      job_valid,
    output logic                                      job_ready,
    input  logic [FRAG_LEN_BITS-1:0]                  job_frag,
    input  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]  job_indices,
    input  logic [$clog2(INDICES_COUNT):0]            job_cnt,
    output logic [FRAG_LEN_BITS-1:0]                  ext_fragment,
    output logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]  ext_kmer_indices,
    output logic                                      ext_valid_indices,
    output logic                                      out_valid,
    output logic [$clog2(INDICES_COUNT)-1:0]          out_slot,
    output logic [$clog2(FRAG_PARTS_COUNT)-1:0]       out_part,
    output logic                                      out_first,
    output logic                                      out_last,
    output logic                                      job_done,
    output logic                                      busy
);

    localparam int PW = $clog2(FRAG_PARTS_COUNT);
    localparam int SW = $clog2(INDICES_COUNT);
    localparam int CW = SW + 1;

    localparam logic [PW-1:0] LAST_PART = PW'(FRAG_PARTS_COUNT - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(INDICES_COUNT - 1);
    localparam logic [CW-1:0] MAX_CNT   = CW'(INDICES_COUNT);

    // Shadow of the extender's own counters; shares rst_n so both stay in lockstep.
    logic [PW-1:0]                            r_part;
    logic [SW-1:0]                            r_slot;

    logic [FRAG_LEN_BITS-1:0]                 r_pend_frag;
    logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] r_pend_idx;
    logic [CW-1:0]                            r_pend_cnt;
    logic                                     r_pend_v;

    logic [FRAG_LEN_BITS-1:0]                 r_act_frag;
    logic [CW-1:0]                            r_act_cnt;
    logic                                     r_act_v;

    logic                                     w_boundary;
    logic                                     w_accept;
    logic [CW-1:0]                            w_cnt_clamped;
    logic [CW-1:0]                            w_slot_ext;
    logic                                     w_out_valid;

    assign w_boundary    = (r_part == LAST_PART) && (r_slot == LAST_SLOT);
    assign w_accept      = job_valid && !r_pend_v;
    assign w_cnt_clamped = (job_cnt > MAX_CNT) ? MAX_CNT : job_cnt;
    assign w_slot_ext    = {1'b0, r_slot};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_part      <= '0;
            r_slot      <= '0;
            r_pend_frag <= '0;
            r_pend_idx  <= '0;
            r_pend_cnt  <= '0;
            r_pend_v    <= 1'b0;
            r_act_frag  <= '0;
            r_act_cnt   <= '0;
            r_act_v     <= 1'b0;
        end else begin
            r_part <= (r_part == LAST_PART) ? '0 : r_part + PW'(1);
            if (r_part == LAST_PART) begin
                r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + SW'(1);
            end

            if (w_accept) begin
                r_pend_frag <= job_frag;
                r_pend_idx  <= job_indices;
                r_pend_cnt  <= w_cnt_clamped;
                r_pend_v    <= 1'b1;
            end

            // Accept needs !pend_v and promotion needs pend_v, so they never collide.
            if (w_boundary) begin
                if (r_pend_v) begin
                    r_act_frag <= r_pend_frag;
                    r_act_cnt  <= r_pend_cnt;
                    r_act_v    <= 1'b1;
                    r_pend_v   <= 1'b0;
                end else begin
                    r_act_v    <= 1'b0;
                end
            end
        end
    end

    assign w_out_valid       = r_act_v && (w_slot_ext < r_act_cnt);

    assign job_ready         = !r_pend_v;
    assign ext_kmer_indices  = r_pend_idx;
    assign ext_valid_indices = r_pend_v && w_boundary;
    assign ext_fragment      = r_act_v ? r_act_frag : '0;
    assign out_valid         = w_out_valid;
    assign out_slot          = r_slot;
    assign out_part          = r_part;
    assign out_first         = w_out_valid && (r_slot == '0) && (r_part == '0);
    assign out_last          = w_out_valid && (w_slot_ext == r_act_cnt - CW'(1)) && (r_part == LAST_PART);
    assign job_done          = w_boundary && r_act_v;
    assign busy              = r_act_v || r_pend_v;

endmodule

// File: tb/tb_proj_extender_ctrl.sv
// tb/tb_proj_extender_ctrl.sv - directed bench with a job-schedule model of the controller
module tb_proj_extender_ctrl;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             job_valid;
    logic             job_ready;
    logic [31:0]      job_frag;
    logic [3:0][7:0]  job_indices;
    logic [2:0]       job_cnt;
    logic [31:0]      ext_fragment;
    logic [3:0][7:0]  ext_kmer_indices;
    logic             ext_valid_indices;
    logic             out_valid;
    logic [1:0]       out_slot;
    logic [2:0]       out_part;
    logic             out_first;
    logic             out_last;
    logic             job_done;
    logic             busy;

    proj_extender_ctrl #(
        .FRAG_LEN_BITS    (32),
        .FRAG_PARTS_COUNT (8),
        .INDICES_COUNT    (4),
        .INDICE_LEN       (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .job_valid         (job_valid),
        .job_ready         (job_ready),
        .job_frag          (job_frag),
        .job_indices       (job_indices),
        .job_cnt           (job_cnt),
        .ext_fragment      (ext_fragment),
        .ext_kmer_indices  (ext_kmer_indices),
        .ext_valid_indices (ext_valid_indices),
        .out_valid         (out_valid),
        .out_slot          (out_slot),
        .out_part          (out_part),
        .out_first         (out_first),
        .out_last          (out_last),
        .job_done          (job_done),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Cycle index since the last reset release; cycle 0 is the cycle where the counters read zero.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    endtask

    task automatic chk_list(input string nm, input int got[$], input int exp[$]);
        chk({nm, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk(nm, 64'(got[i]), 64'(exp[i]));
    endtask

    // A job accepted in cycle a owns the whole round that starts right after the next boundary.
    typedef struct {
        int          a;
        int          r;
        logic [31:0] frag;
        logic [31:0] idx;
        int          cnt;
    } job_t;

    job_t jobs[$];
    int   ev_evi[$], ev_first[$], ev_last[$], ev_done[$];
    int   ov_cycles = 0;

    int          m_part, m_slot, m_ai, m_pi, m_cnt;
    logic        m_bnd, m_ready, m_ov, m_first, m_last, m_evi, m_done, m_busy;
    logic [31:0] m_frag, m_kidx;
    job_t        m_new;

    always @(negedge clk) begin
        if (!rst_n) jobs.delete();
        m_part = cyc % 8;
        m_slot = (cyc / 8) % 4;
        m_bnd  = (cyc % 32) == 31;
        m_ai   = -1;
        m_pi   = -1;
        foreach (jobs[i]) begin
            if (cyc >= jobs[i].r * 32 && cyc < jobs[i].r * 32 + 32) m_ai = i;
            if (cyc > jobs[i].a && cyc < jobs[i].r * 32) m_pi = i;
        end
        m_ready = (m_pi < 0);
        m_ov = 1'b0; m_first = 1'b0; m_last = 1'b0; m_frag = '0;
        if (m_ai >= 0) begin
            m_cnt   = jobs[m_ai].cnt;
            m_frag  = jobs[m_ai].frag;
            m_ov    = m_slot < m_cnt;
            m_first = m_ov && m_slot == 0 && m_part == 0;
            m_last  = m_ov && m_slot == m_cnt - 1 && m_part == 7;
        end
        m_kidx = (jobs.size() > 0) ? jobs[jobs.size()-1].idx : 32'h0;
        m_evi  = (m_pi >= 0) && m_bnd;
        m_done = (m_ai >= 0) && m_bnd;
        m_busy = (m_ai >= 0) || (m_pi >= 0);

        chk("job_ready",         64'(job_ready),          64'(m_ready));
        chk("out_valid",         64'(out_valid),          64'(m_ov));
        chk("out_first",         64'(out_first),          64'(m_first));
        chk("out_last",          64'(out_last),           64'(m_last));
        chk("out_slot",          64'(out_slot),           64'(m_slot));
        chk("out_part",          64'(out_part),           64'(m_part));
        chk("ext_fragment",      64'(ext_fragment),       64'(m_frag));
        chk("ext_kmer_indices",  64'(ext_kmer_indices),   64'(m_kidx));
        chk("ext_valid_indices", 64'(ext_valid_indices),  64'(m_evi));
        chk("job_done",          64'(job_done),           64'(m_done));
        chk("busy",              64'(busy),               64'(m_busy));

        if (ext_valid_indices) ev_evi.push_back(cyc);
        if (out_first)         ev_first.push_back(cyc);
        if (out_last)          ev_last.push_back(cyc);
        if (job_done)          ev_done.push_back(cyc);
        if (out_valid)         ov_cycles++;

        if (rst_n && job_valid && m_ready) begin
            m_new.a    = cyc;
            m_new.r    = (cyc + 1) / 32 + 1;
            m_new.frag = job_frag;
            m_new.idx  = job_indices;
            m_new.cnt  = (job_cnt > 3'd4) ? 4 : int'(job_cnt);
            jobs.push_back(m_new);
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer(input int at, input logic [31:0] frag, input logic [31:0] idx, input logic [2:0] cnt);
        wait_cyc(at);
        job_valid   = 1'b1;
        job_frag    = frag;
        job_indices = idx;
        job_cnt     = cnt;
        @(posedge clk);
        #1;
        job_valid   = 1'b0;
        job_frag    = '0;
        job_indices = '0;
        job_cnt     = '0;
    endtask

    int exp_evi[$], exp_first[$], exp_last[$], exp_done[$];

    initial begin
        rst_n = 1'b0; job_valid = 1'b0; job_frag = '0; job_indices = '0; job_cnt = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        offer(3,   32'hA0A0_0001, 32'h0403_0201, 3'd4);
        offer(40,  32'hB0B0_0002, 32'h1413_1211, 3'd4);
        offer(50,  32'hDEAD_BEEF, 32'hFFFF_FFFF, 3'd1);   // ignored: B still pending
        offer(70,  32'hC0C0_0003, 32'h2423_2221, 3'd2);
        offer(100, 32'hD0D0_0004, 32'h3433_3231, 3'd0);
        offer(191, 32'hE0E0_0005, 32'h4443_4241, 3'd7);   // on a boundary, count clamps to 4
        offer(230, 32'hF0F0_0006, 32'h5453_5251, 3'd3);
        offer(260, 32'h1111_0007, 32'h6463_6261, 3'd4);

        wait_cyc(270);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        offer(5, 32'h2222_0008, 32'h7473_7271, 3'd1);
        wait_cyc(70);
        @(negedge clk);

        exp_evi   = '{31, 63, 95, 127, 223, 255, 31};
        exp_first = '{32, 64, 96, 224, 256, 32};
        exp_last  = '{63, 95, 111, 255, 39};
        exp_done  = '{63, 95, 127, 159, 255, 63};
        chk_list("evi_cycles",   ev_evi,   exp_evi);
        chk_list("first_cycles", ev_first, exp_first);
        chk_list("last_cycles",  ev_last,  exp_last);
        chk_list("done_cycles",  ev_done,  exp_done);
        chk("out_valid_cycles", 64'(ov_cycles), 64'd134);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
